// File: rtl/operand_fetch_if.sv
// operand_fetch_if: decode-side issue, write-back and ALU-side operand signals
// of the register-read stage, bundled with directional modports.
interface operand_fetch_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int OP_W   = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_rs_addr;
  logic [ADDR_W-1:0] in_rt_addr;
  logic [OP_W-1:0]   in_op;
  logic [ADDR_W-1:0] in_rd_addr;
  logic              in_we;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_rs;
  logic [DATA_W-1:0] out_rt;
  logic [OP_W-1:0]   out_op;
  logic [ADDR_W-1:0] out_rd_addr;
  logic              out_we;

  // The register-read stage itself.
  modport slave (
    input  in_valid, in_rs_addr, in_rt_addr, in_op, in_rd_addr, in_we,
    input  wb_en, wb_addr, wb_data, out_ready,
    output in_ready, out_valid, out_rs, out_rt, out_op, out_rd_addr, out_we
  );

  // Decode / write-back / execute side driving the stage.
  modport master (
    output in_valid, in_rs_addr, in_rt_addr, in_op, in_rd_addr, in_we,
    output wb_en, wb_addr, wb_data, out_ready,
    input  in_ready, out_valid, out_rs, out_rt, out_op, out_rd_addr, out_we
  );
endinterface

// File: rtl/operand_fetch.sv
// operand_fetch: register-read stage for the 16-bit ALU. Holds the register
// file, reads two sources with write-back bypass, and presents registered
// operands plus opcode through a valid/ready handshake (latency 1).
module operand_fetch #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int OP_W     = 4,
  parameter int ZERO_REG = 1
) (
  input logic           clk,
  input logic           rst_n,
  operand_fetch_if.slave bus
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NREG];

  logic              vld_p1;
  logic [DATA_W-1:0] rs_p1;
  logic [DATA_W-1:0] rt_p1;
  logic [OP_W-1:0]   op_p1;
  logic [ADDR_W-1:0] rd_p1;
  logic              we_p1;
  logic [ADDR_W-1:0] rs_addr_p1;
  logic [ADDR_W-1:0] rt_addr_p1;

  logic              accept_p0;
  logic              stall_p1;
  logic [DATA_W-1:0] rs_p0;
  logic [DATA_W-1:0] rt_p0;
  logic              snoop_rs_p1;
  logic              snoop_rt_p1;

  // Register 0 is hard-wired to zero only when ZERO_REG is set.
  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Source read: zero register wins, then same-cycle write-back, then the file.
  function automatic logic [DATA_W-1:0] read_src(
    input logic [ADDR_W-1:0] a,
    input logic [DATA_W-1:0] stored,
    input logic              wen,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata
  );
    if (is_zero_reg(a)) return '0;
    if (wen && (waddr == a)) return wdata;
    return stored;
  endfunction

  // ---- stage p0: read / bypass / handshake ----
  assign bus.in_ready = !vld_p1 || bus.out_ready;
  assign accept_p0    = bus.in_valid && bus.in_ready;
  assign stall_p1     = vld_p1 && !bus.out_ready;

  assign rs_p0 = read_src(bus.in_rs_addr, regs[bus.in_rs_addr], bus.wb_en, bus.wb_addr, bus.wb_data);
  assign rt_p0 = read_src(bus.in_rt_addr, regs[bus.in_rt_addr], bus.wb_en, bus.wb_addr, bus.wb_data);

  // A held operand follows write-back to its source while the ALU stalls.
  assign snoop_rs_p1 = bus.wb_en && (bus.wb_addr == rs_addr_p1) && !is_zero_reg(rs_addr_p1);
  assign snoop_rt_p1 = bus.wb_en && (bus.wb_addr == rt_addr_p1) && !is_zero_reg(rt_addr_p1);

  // Register file write port; writes to the zero register are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (bus.wb_en && !is_zero_reg(bus.wb_addr)) begin
      regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  // ---- stage p1: output register toward the ALU ----
  // Load on accept, drain on consume, hold and snoop write-back while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      rs_p1      <= '0;
      rt_p1      <= '0;
      op_p1      <= '0;
      rd_p1      <= '0;
      we_p1      <= 1'b0;
      rs_addr_p1 <= '0;
      rt_addr_p1 <= '0;
    end else if (accept_p0) begin
      vld_p1     <= 1'b1;
      rs_p1      <= rs_p0;
      rt_p1      <= rt_p0;
      op_p1      <= bus.in_op;
      rd_p1      <= bus.in_rd_addr;
      we_p1      <= bus.in_we;
      rs_addr_p1 <= bus.in_rs_addr;
      rt_addr_p1 <= bus.in_rt_addr;
    end else begin
      if (bus.out_ready) vld_p1 <= 1'b0;
      if (stall_p1 && snoop_rs_p1) rs_p1 <= bus.wb_data;
      if (stall_p1 && snoop_rt_p1) rt_p1 <= bus.wb_data;
    end
  end

  assign bus.out_valid   = vld_p1;
  assign bus.out_rs      = rs_p1;
  assign bus.out_rt      = rt_p1;
  assign bus.out_op      = op_p1;
  assign bus.out_rd_addr = rd_p1;
  assign bus.out_we      = we_p1;

endmodule
